// File: rtl/float32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : float32_pkg
// Description : Shared float32 / int32 constants and the classification
//               enum used by the float<->int streaming converters.
// Revision    : 1.0 - initial release
// ============================================================================
package float32_pkg;

   localparam int          F32_BIAS  = 127;
   localparam int          F32_EXP_W = 8;
   localparam int          F32_MAN_W = 23;

   localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] INT32_MIN = 32'h8000_0000;

   // Bit positions inside the 2-bit tuser side channel
   localparam int          TUSER_SAT = 0;
   localparam int          TUSER_NAN = 1;

   // Outcome of classifying one float32 sample for conversion
   typedef enum logic [1:0] {
      ZERO   = 2'd0,
      NORMAL = 2'd1,
      SAT    = 2'd2,
      NAN    = 2'd3
   } f32_class_e;

endpackage : float32_pkg
`default_nettype wire

// File: rtl/f32_classify.sv
`default_nettype none
// ============================================================================
// Module      : f32_classify
// Description : Combinational float32 field split and classification.
//               Produces class, sign, effective exponent (biased exponent
//               minus bias plus fractional bits) and the 24-bit magnitude
//               with the hidden one restored.
// Revision    : 1.0 - initial release
// ============================================================================
module f32_classify
   import float32_pkg::*;
#(
   parameter int FRAC_BITS = 0
) (
   input  logic [31:0]       word,
   output f32_class_e        cls,
   output logic              sign,
   output logic signed [9:0] exp_eff,
   output logic [23:0]       mag
);

   logic [F32_EXP_W-1:0] biased;
   logic [F32_MAN_W-1:0] man;

   assign biased  = word[30:F32_MAN_W];
   assign man     = word[F32_MAN_W-1:0];
   assign sign    = word[31];
   assign mag     = {1'b1, man};
   assign exp_eff = {2'b00, biased} - 10'(F32_BIAS) + 10'(FRAC_BITS);

   // Decide which output path the sample takes; -2^31 with an exact
   // exponent of 31 is representable and goes through the normal path.
   always_comb begin
      cls = ZERO;
      if (biased == '0) begin
         cls = ZERO;
      end else if (biased == '1) begin
         if (man != '0) cls = NAN;
         else           cls = SAT;
      end else if (exp_eff < 10'sd0) begin
         cls = ZERO;
      end else if (exp_eff >= 10'sd31) begin
         if (sign && (exp_eff == 10'sd31) && (man == '0)) cls = NORMAL;
         else                                              cls = SAT;
      end else begin
         cls = NORMAL;
      end
   end

endmodule : f32_classify
`default_nettype wire

// File: rtl/float_to_int_axi.sv
`default_nettype none
// ============================================================================
// Module      : float_to_int_axi
// Description : Streaming float32 to signed Q(31-FRAC_BITS).FRAC_BITS
//               converter. Three-stage pipeline (classify, shift,
//               sign/saturate) with full AXI-stream backpressure. Rounds
//               toward zero, saturates on overflow, tuser = {nan, sat}.
//               FRAC_BITS legal range is 0..16.
// Revision    : 1.0 - initial release
// ============================================================================
module float_to_int_axi
   import float32_pkg::*;
#(
   parameter int FRAC_BITS = 0
) (
   input  logic        aclk,
   input  logic        rst,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic [1:0]  m_axis_tuser,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready
);

   logic              en1, en2, en3;
   logic              v1, v2, v3;

   f32_class_e        cls_in;
   logic              sign_in;
   logic signed [9:0] exp_in;
   logic [23:0]       mag_in;

   f32_class_e        s1_cls;
   logic              s1_sign;
   logic signed [9:0] s1_exp;
   logic [23:0]       s1_mag;

   logic [4:0]        lsh, rsh;
   logic [31:0]       shifted;

   f32_class_e        s2_cls;
   logic              s2_sign;
   logic [31:0]       s2_mag;

   logic [31:0]       result;
   logic [1:0]        result_user;
   logic [31:0]       s3_data;
   logic [1:0]        s3_user;

   f32_classify #(
      .FRAC_BITS (FRAC_BITS)
   ) u_classify (
      .word    (s_axis_tdata),
      .cls     (cls_in),
      .sign    (sign_in),
      .exp_eff (exp_in),
      .mag     (mag_in)
   );

   // Each stage may advance when it is empty or its successor advances
   always_comb begin
      en3 = !v3 || m_axis_tready;
      en2 = !v2 || en3;
      en1 = !v1 || en2;
   end

   assign s_axis_tready = en1;
   assign m_axis_tvalid = v3;
   assign m_axis_tdata  = s3_data;
   assign m_axis_tuser  = s3_user;

   // Valid bits ripple forward on their stage enables
   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (en1) v1 <= s_axis_tvalid;
         if (en2) v2 <= v1;
         if (en3) v3 <= v2;
      end
   end

   // S1: capture the classified input sample
   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         s1_cls  <= ZERO;
         s1_sign <= 1'b0;
         s1_exp  <= '0;
         s1_mag  <= '0;
      end else if (en1 && s_axis_tvalid) begin
         s1_cls  <= cls_in;
         s1_sign <= sign_in;
         s1_exp  <= exp_in;
         s1_mag  <= mag_in;
      end
   end

   // Align the magnitude to the output binary point; only normal samples
   // (exponent 0..31) carry a meaningful magnitude past this point.
   always_comb begin
      lsh     = s1_exp[4:0] - 5'd23;
      rsh     = 5'd23 - s1_exp[4:0];
      shifted = '0;
      if (s1_cls == NORMAL) begin
         if (s1_exp >= 10'sd23) shifted = {8'd0, s1_mag} << lsh;
         else                   shifted = {8'd0, s1_mag} >> rsh;
      end
   end

   // S2: register the shifted magnitude
   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         s2_cls  <= ZERO;
         s2_sign <= 1'b0;
         s2_mag  <= '0;
      end else if (en2 && v1) begin
         s2_cls  <= s1_cls;
         s2_sign <= s1_sign;
         s2_mag  <= shifted;
      end
   end

   // Apply sign, saturation and the exception flags
   always_comb begin
      result      = '0;
      result_user = '0;
      case (s2_cls)
         NORMAL: result = s2_sign ? (~s2_mag + 32'd1) : s2_mag;
         SAT: begin
            result                 = s2_sign ? INT32_MIN : INT32_MAX;
            result_user[TUSER_SAT] = 1'b1;
         end
         NAN: result_user[TUSER_NAN] = 1'b1;
         default: result = '0;
      endcase
   end

   // S3: output register, held while downstream stalls
   always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
         s3_data <= '0;
         s3_user <= '0;
      end else if (en3 && v2) begin
         s3_data <= result;
         s3_user <= result_user;
      end
   end

endmodule : float_to_int_axi
`default_nettype wire

// File: tb/tb_float_to_int_axi.sv
`default_nettype none
// ============================================================================
// Module      : tb_float_to_int_axi
// Description : Self-checking bench for float_to_int_axi. Two instances
//               (FRAC_BITS 0 and 8) share one input stream; directed
//               vectors plus latency, backpressure and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_float_to_int_axi;

   logic        aclk = 1'b0;
   logic        rst;
   logic [31:0] s_data;
   logic        s_valid;
   logic        m_ready;

   logic        s_ready0, m_valid0, s_ready8, m_valid8;
   logic [31:0] m_data0, m_data8;
   logic [1:0]  m_user0, m_user8;

   int n_vec = 0;
   int n_err = 0;

   always #5 aclk = ~aclk;

   float_to_int_axi #(.FRAC_BITS(0)) dut0 (
      .aclk          (aclk),
      .rst           (rst),
      .s_axis_tdata  (s_data),
      .s_axis_tvalid (s_valid),
      .s_axis_tready (s_ready0),
      .m_axis_tdata  (m_data0),
      .m_axis_tuser  (m_user0),
      .m_axis_tvalid (m_valid0),
      .m_axis_tready (m_ready)
   );

   float_to_int_axi #(.FRAC_BITS(8)) dut8 (
      .aclk          (aclk),
      .rst           (rst),
      .s_axis_tdata  (s_data),
      .s_axis_tvalid (s_valid),
      .s_axis_tready (s_ready8),
      .m_axis_tdata  (m_data8),
      .m_axis_tuser  (m_user8),
      .m_axis_tvalid (m_valid8),
      .m_axis_tready (m_ready)
   );

   typedef struct {
      int          frac;
      logic [31:0] din;
      logic [31:0] dout;
      logic [1:0]  user;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   initial begin
      logic [31:0] bp_in[10];
      logic [31:0] bp_exp[10];
      int acc, emit, occ, cyc;
      bit hs_in, hs_out;
      logic [31:0] act_d;
      logic [1:0]  act_u;
      logic        act_v;

      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      #2;
      check("reset_tvalid", 32'(m_valid0), 32'd0);
      check("reset_tdata",  m_data0, 32'd0);
      check("reset_tuser",  32'(m_user0), 32'd0);
      check("reset_tready", 32'(s_ready0), 32'd1);
      check("reset_tready8", 32'(s_ready8), 32'd1);
      #10;
      rst = 1'b0;
      step();

      // ---------------- single-sample directed vectors ----------------
      vecs[0]  = '{0, 32'h3FC0_0000, 32'h0000_0001, 2'b00};
      vecs[1]  = '{0, 32'hBFC0_0000, 32'hFFFF_FFFF, 2'b00};
      vecs[2]  = '{0, 32'h4B00_0001, 32'h0080_0001, 2'b00};
      vecs[3]  = '{0, 32'h4F00_0000, 32'h7FFF_FFFF, 2'b01};
      vecs[4]  = '{0, 32'hCF00_0000, 32'h8000_0000, 2'b00};
      vecs[5]  = '{0, 32'hCF00_0001, 32'h8000_0000, 2'b01};
      vecs[6]  = '{0, 32'h3F7F_FFFF, 32'h0000_0000, 2'b00};
      vecs[7]  = '{0, 32'h7FC0_0000, 32'h0000_0000, 2'b10};
      vecs[8]  = '{0, 32'h7F80_0000, 32'h7FFF_FFFF, 2'b01};
      vecs[9]  = '{0, 32'hFF80_0000, 32'h8000_0000, 2'b01};
      vecs[10] = '{0, 32'h0000_0001, 32'h0000_0000, 2'b00};
      vecs[11] = '{0, 32'h8000_0000, 32'h0000_0000, 2'b00};
      vecs[12] = '{0, 32'hC2F6_0000, 32'hFFFF_FF85, 2'b00};
      vecs[13] = '{0, 32'h4A80_0001, 32'h0040_0000, 2'b00};
      vecs[14] = '{8, 32'h3FC0_0000, 32'h0000_0180, 2'b00};
      vecs[15] = '{8, 32'h4700_0000, 32'h0080_0000, 2'b00};
      vecs[16] = '{8, 32'h4B00_0000, 32'h7FFF_FFFF, 2'b01};
      vecs[17] = '{8, 32'hBFC0_0000, 32'hFFFF_FE80, 2'b00};

      for (int i = 0; i < 18; i++) begin
         s_data = vecs[i].din; s_valid = 1'b1;
         step();                 // accepted on this edge
         s_valid = 1'b0;
         step();
         step();                 // two edges later the result is presented
         act_v = (vecs[i].frac == 8) ? m_valid8 : m_valid0;
         act_d = (vecs[i].frac == 8) ? m_data8  : m_data0;
         act_u = (vecs[i].frac == 8) ? m_user8  : m_user0;
         check($sformatf("vec%0d_valid", i), 32'(act_v), 32'd1);
         check($sformatf("vec%0d_data", i), act_d, vecs[i].dout);
         check($sformatf("vec%0d_user", i), 32'(act_u), 32'(vecs[i].user));
         step();
      end

      // ---------------- back-to-back latency / throughput ----------------
      s_valid = 1'b1; s_data = 32'h3FC0_0000;
      step();
      s_data = 32'hBFC0_0000;
      check("b2b_k_valid", 32'(m_valid0), 32'd0);
      step();
      s_data = 32'h4B00_0001;
      check("b2b_k1_valid", 32'(m_valid0), 32'd0);
      step();
      s_valid = 1'b0;
      check("b2b_out0_valid", 32'(m_valid0), 32'd1);
      check("b2b_out0", m_data0, 32'h0000_0001);
      step();
      check("b2b_out1", m_data0, 32'hFFFF_FFFF);
      check("b2b_out1_valid", 32'(m_valid0), 32'd1);
      step();
      check("b2b_out2", m_data0, 32'h0080_0001);
      check("b2b_out2_user", 32'(m_user0), 32'd0);
      step();
      check("b2b_drained", 32'(m_valid0), 32'd0);

      // ---------------- backpressure ----------------
      for (int i = 0; i < 10; i++) begin
         bp_in[i]  = 32'h3F80_0000 + (32'(i) << 22);
      end
      bp_in  = '{32'h3F80_0000, 32'h4000_0000, 32'hC040_0000, 32'h4080_0000, 32'h40A0_0000,
                 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000, 32'h4120_0000};
      bp_exp = '{32'd1, 32'd2, 32'hFFFF_FFFD, 32'd4, 32'd5,
                 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
      acc = 0; emit = 0; occ = 0; cyc = 0;
      while (emit < 10 && cyc < 300) begin
         if (cyc < 4)       m_ready = 1'b1;
         else if (cyc <= 9) m_ready = 1'b0;
         else               m_ready = 1'($urandom_range(0, 1));
         s_valid = (acc < 10);
         if (acc < 10) s_data = bp_in[acc];
         @(negedge aclk);
         check($sformatf("bp_tready_c%0d", cyc), 32'(s_ready0), 32'((occ < 3) || m_ready));
         if (m_valid0) begin
            check($sformatf("bp_data%0d", emit), m_data0, bp_exp[emit]);
            check($sformatf("bp_user%0d", emit), 32'(m_user0), 32'd0);
         end
         hs_in  = s_valid && s_ready0;
         hs_out = m_valid0 && m_ready;
         step();
         if (hs_in)  begin acc++;  occ++; end
         if (hs_out) begin emit++; occ--; end
         cyc++;
      end
      n_vec++;
      if (emit != 10) begin
         n_err++;
         $display("FAIL bp_timeout: got %0d outputs, required 10", emit);
      end
      s_valid = 1'b0; m_ready = 1'b1;
      step();
      check("bp_no_dup", 32'(m_valid0), 32'd0);

      // ---------------- reset mid-stream ----------------
      m_ready = 1'b0; s_valid = 1'b1;
      s_data = 32'h3F80_0000; step();
      s_data = 32'h4000_0000; step();
      s_data = 32'h4040_0000; step();
      s_valid = 1'b0;
      check("rst_full_valid", 32'(m_valid0), 32'd1);
      check("rst_full_tready", 32'(s_ready0), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_valid", 32'(m_valid0), 32'd0);
      check("rst_async_data",  m_data0, 32'd0);
      check("rst_async_user",  32'(m_user0), 32'd0);
      check("rst_async_tready", 32'(s_ready0), 32'd1);
      step();
      step();
      rst = 1'b0;
      m_ready = 1'b1;
      s_data = 32'h40A0_0000; s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      check("rst_post_k", 32'(m_valid0), 32'd0);
      step();
      check("rst_post_k1", 32'(m_valid0), 32'd0);
      step();
      check("rst_post_valid", 32'(m_valid0), 32'd1);
      check("rst_post_data", m_data0, 32'd5);
      step();
      check("rst_post_nostale", 32'(m_valid0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time guard so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_float_to_int_axi
`default_nettype wire
